inst_queue: RTL

- Receiving end of the IF/ID valid/ready handshake: accepts fetched pipe_if_t entries (vaddr, inst) from inst_fetch and buffers them for the decode stage.
- Decouples fetch from decode stalls, so the icache keeps streaming while ID is blocked.
- A synchronous flush discards all buffered entries on branch mispredict or exception redirect.
- Sits between inst_fetch and the ID stage in the cpu top.

---
 rtl/cpu_defs_pkg.sv | 19 +
 rtl/inst_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared pipeline types and sizing constants used across the cpu top.
// pipe_if_t is the IF/ID payload; iq_state_e names the inst_queue occupancy states.
package cpu_defs;

    localparam int XLEN             = 32;
    localparam int INST_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] vaddr;
        logic [XLEN-1:0] inst;
    } pipe_if_t;

    typedef enum logic [1:0] {
        IQ_EMPTY   = 2'd0,
        IQ_PARTIAL = 2'd1,
        IQ_FULL    = 2'd2
    } iq_state_e;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: IF/ID decoupling FIFO buffering fetched {vaddr, inst} entries for decode.
// Optional zero-latency pass-through of an empty queue when INST_QUEUE_BYPASS_EN is defined.
module inst_queue
    import cpu_defs::*;
#(
    parameter int DEPTH      = INST_QUEUE_DEPTH,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      ifid_valid,
    output logic                      ifid_ready,
    input  logic [2*DATA_WIDTH-1:0]   ifid_data,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [2*DATA_WIDTH-1:0]   id_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW  = $clog2(DEPTH) + 1;
    localparam int IW  = PW - 1;
    localparam int PLW = 2 * DATA_WIDTH;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]  r_wrPtr;
    logic [PW-1:0]  r_rdPtr;
    logic [PLW-1:0] r_mem [DEPTH];
    logic           r_active;

    iq_state_e      w_state;
    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_bypass;
    logic [IW-1:0]  w_wrIdx;
    logic [IW-1:0]  w_rdIdx;

    assign w_wrIdx = r_wrPtr[IW-1:0];
    assign w_rdIdx = r_rdPtr[IW-1:0];

    // Equal index bits with unequal pointers can only mean the wrap bits differ.
    always_comb begin
        w_state = IQ_PARTIAL;
        if (r_wrPtr == r_rdPtr) begin
            w_state = IQ_EMPTY;
        end else if (w_wrIdx == w_rdIdx) begin
            w_state = IQ_FULL;
        end
    end

    assign w_empty = (w_state == IQ_EMPTY);
    assign w_full  = (w_state == IQ_FULL);

    // r_active holds ready low until the first clock after reset release.
    assign ifid_ready = r_active && !w_full && !flush;

    always_comb begin
        id_valid = !w_empty && !flush;
        id_data  = r_mem[w_rdIdx];
        w_bypass = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        if (w_empty && !flush) begin
            id_valid = ifid_valid;
            id_data  = ifid_data;
            w_bypass = ifid_valid && id_ready;
        end
`endif
    end

    assign w_push = ifid_valid && ifid_ready && !w_bypass;
    assign w_pop  = id_valid && id_ready && !w_empty;
    assign count  = r_wrPtr - r_rdPtr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_active <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_active <= 1'b1;
            if (flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) begin
                    r_mem[w_wrIdx] <= ifid_data;
                    r_wrPtr        <= r_wrPtr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_ONE;
                end
            end
        end
    end

endmodule
